// File: rtl/array_unpack.sv
// -----------------------------------------------------------------------------
// array_unpack
//
// Streaming lane unpacker. Takes one packed word of NUM_LANES lanes of
// LANE_WIDTH bits on the input handshake and emits it one lane per cycle on
// the output handshake. LSB_FIRST selects the emission order: 1 = lane 0
// first, 0 = lane NUM_LANES-1 first.
//
// Handshake rule (both sides): a transfer happens on a rising CLK edge where
// valid && ready. Once valid is high, valid and its payload hold steady until
// that transfer. Ready may depend on the other side's ready, never on this
// side's valid.
//
// Ports
//   CLK          sole clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   I_valid      packed word present
//   I_ready      word accepted this cycle (combinational from O_ready)
//   I_data       packed word, lane k = I_data[k*LANE_WIDTH +: LANE_WIDTH]
//   O_valid      lane present
//   O_ready      consumer takes the lane this cycle
//   O_data       current lane
//   O_index      physical lane number of O_data
//   O_last       final lane of the word
//   dbg_state    FSM state (0 = IDLE, 1 = EMIT)
// -----------------------------------------------------------------------------
module array_unpack #(
   parameter int LANE_WIDTH = 4,
   parameter int NUM_LANES  = 4,
   parameter bit LSB_FIRST  = 1'b1,
   localparam int IDXW      = $clog2(NUM_LANES)
) (
   input  logic                            CLK,
   input  logic                            ASYNCRESETN,
   input  logic                            I_valid,
   output logic                            I_ready,
   input  logic [LANE_WIDTH*NUM_LANES-1:0] I_data,
   output logic                            O_valid,
   input  logic                            O_ready,
   output logic [LANE_WIDTH-1:0]           O_data,
   output logic [IDXW-1:0]                 O_index,
   output logic                            O_last,
   output logic                            dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [IDXW-1:0] LAST_POS = IDXW'(NUM_LANES - 1);

   state_t                          state;
   logic [IDXW-1:0]                 cnt;
   logic [LANE_WIDTH*NUM_LANES-1:0] hold;

   logic busy;
   logic in_xfer;
   logic out_xfer;

   assign busy     = (state == EMIT);
   assign O_valid  = busy;
   assign O_last   = busy && (cnt == LAST_POS);
   assign O_index  = LSB_FIRST ? cnt : (LAST_POS - cnt);

   // A new word may enter only when nothing is held, or when the final lane
   // leaves on this very edge; reset forces it low.
   assign I_ready  = ASYNCRESETN && (!busy || (O_ready && O_last));

   assign in_xfer  = I_valid && I_ready;
   assign out_xfer = O_valid && O_ready;

   assign dbg_state = state;

   // Lane mux: outputs come straight from hold/cnt, never from I_*.
   always_comb begin
      O_data = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (IDXW'(k) == O_index) begin
            O_data = hold[k*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= IDLE;
         cnt   <= '0;
         hold  <= '0;
      end else if (in_xfer) begin
         // Loading wins over retiring the last lane: back-to-back words.
         hold  <= I_data;
         cnt   <= '0;
         state <= EMIT;
      end else if (out_xfer) begin
         if (O_last) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt   <= cnt + IDXW'(1);
         end
      end
   end

endmodule

// File: tb/tb_array_unpack.sv
module tb_array_unpack;

   localparam int LW = 4;
   localparam int NL = 4;

   typedef struct packed {
      logic [LW-1:0] data;
      logic [1:0]    idx;
      logic          last;
   } lane_t;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          I_valid = 1'b0;
   logic [15:0]   I_data = '0;
   logic          O_ready = 1'b1;

   logic          l_iready, l_ovalid, l_olast, l_dbg;
   logic [LW-1:0] l_odata;
   logic [1:0]    l_oidx;
   logic          m_iready, m_ovalid, m_olast, m_dbg;
   logic [LW-1:0] m_odata;
   logic [1:0]    m_oidx;

   int checks = 0;
   int errors = 0;

   lane_t q_lsb[$];
   lane_t q_msb[$];

   always #5 CLK = ~CLK;

   array_unpack #(.LANE_WIDTH(LW), .NUM_LANES(NL), .LSB_FIRST(1'b1)) dut_lsb (
      .CLK(CLK), .ASYNCRESETN(rst_n),
      .I_valid(I_valid), .I_ready(l_iready), .I_data(I_data),
      .O_valid(l_ovalid), .O_ready(O_ready), .O_data(l_odata),
      .O_index(l_oidx), .O_last(l_olast), .dbg_state(l_dbg)
   );

   array_unpack #(.LANE_WIDTH(LW), .NUM_LANES(NL), .LSB_FIRST(1'b0)) dut_msb (
      .CLK(CLK), .ASYNCRESETN(rst_n),
      .I_valid(I_valid), .I_ready(m_iready), .I_data(I_data),
      .O_valid(m_ovalid), .O_ready(O_ready), .O_data(m_odata),
      .O_index(m_oidx), .O_last(m_olast), .dbg_state(m_dbg)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // Each accepted word becomes NL pending lane records in emission order;
   // the head of the queue is what the consumer must see next.
   function automatic bit model_iready(int qsize);
      return rst_n && (qsize == 0 || (O_ready && qsize == 1));
   endfunction

   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         q_lsb.delete();
         q_msb.delete();
      end else begin
         bit take_in;
         take_in = I_valid && model_iready(q_lsb.size());
         if (q_lsb.size() != 0 && O_ready) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
         end
         if (take_in) begin
            for (int p = 0; p < NL; p++) begin
               lane_t e;
               int    k;
               k      = p;
               e.idx  = 2'(k);
               e.data = I_data[k*LW +: LW];
               e.last = (p == NL - 1);
               q_lsb.push_back(e);
               k      = NL - 1 - p;
               e.idx  = 2'(k);
               e.data = I_data[k*LW +: LW];
               q_msb.push_back(e);
            end
         end
      end
   end

   function automatic void cmp_dut(string tag, bit lsb, int qsize, lane_t front,
                                   logic ov, logic ir, logic [LW-1:0] od,
                                   logic [1:0] oi, logic ol);
      if (!rst_n) begin
         chk({tag, "_rst_valid"}, ov, 0);
         chk({tag, "_rst_ready"}, ir, 0);
         chk({tag, "_rst_data"},  od, 0);
         chk({tag, "_rst_index"}, oi, lsb ? 0 : NL - 1);
         chk({tag, "_rst_last"},  ol, 0);
      end else begin
         chk({tag, "_valid"}, ov, qsize != 0);
         chk({tag, "_ready"}, ir, model_iready(qsize));
         if (qsize != 0) begin
            chk({tag, "_data"},  od, front.data);
            chk({tag, "_index"}, oi, front.idx);
            chk({tag, "_last"},  ol, front.last);
         end
      end
   endfunction

   always @(negedge CLK) begin
      lane_t fl, fm;
      fl = (q_lsb.size() != 0) ? q_lsb[0] : '0;
      fm = (q_msb.size() != 0) ? q_msb[0] : '0;
      cmp_dut("lsb", 1'b1, q_lsb.size(), fl, l_ovalid, l_iready, l_odata, l_oidx, l_olast);
      cmp_dut("msb", 1'b0, q_msb.size(), fm, m_ovalid, m_iready, m_odata, m_oidx, m_olast);
   end

   // ---------------- directed stimulus ----------------
   logic [LW-1:0] a5_lsb[4] = '{4'h3, 4'hC, 4'h5, 4'hA};
   logic [LW-1:0] a5_msb[4] = '{4'hA, 4'h5, 4'hC, 4'h3};
   logic [LW-1:0] b2b[8]    = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hC, 4'hD, 4'hE, 4'hF};
   logic [LW-1:0] ff_lsb[4] = '{4'hF, 4'h0, 4'hF, 4'h0};

   task automatic offer_word(input logic [15:0] w);
      @(negedge CLK);
      #1;
      I_valid = 1'b1;
      I_data  = w;
      @(posedge CLK);
      #1;
      I_valid = 1'b0;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst0_lsb_index", l_oidx, 0);
      chk("rst0_msb_index", m_oidx, 3);
      chk("rst0_iready",    l_iready, 0);
      chk("rst0_ovalid",    l_ovalid, 0);
      @(posedge CLK);
      @(posedge CLK);
      #1 rst_n = 1'b1;
      @(negedge CLK);
      chk("idle_iready", l_iready, 1);

      // A5C3 in both orders, continuous ready
      offer_word(16'hA5C3);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("a5_lsb_data",  l_odata, a5_lsb[i]);
         chk("a5_lsb_index", l_oidx,  i);
         chk("a5_lsb_last",  l_olast, i == 3);
         chk("a5_iready",    l_iready, i == 3);
         chk("a5_msb_data",  m_odata, a5_msb[i]);
         chk("a5_msb_index", m_oidx,  3 - i);
      end
      @(negedge CLK);
      chk("a5_done_valid", l_ovalid, 0);

      // back-to-back 1234 then FEDC with I_valid held high
      #1;
      I_valid = 1'b1;
      I_data  = 16'h1234;
      @(posedge CLK);
      #1 I_data = 16'hFEDC;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         chk("b2b_valid", l_ovalid, 1);
         chk("b2b_data",  l_odata, b2b[i]);
         chk("b2b_last",  l_olast, (i == 3) || (i == 7));
         if (i == 3) begin
            @(posedge CLK);
            #1 I_valid = 1'b0;
         end
      end
      @(negedge CLK);
      chk("b2b_done_valid", l_ovalid, 0);

      // O_ready low for three cycles while showing lane 1
      offer_word(16'hA5C3);
      @(negedge CLK);
      chk("stall_lane0", l_odata, 4'h3);
      @(posedge CLK);
      #1 O_ready = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         chk("stall_data",   l_odata, 4'hC);
         chk("stall_index",  l_oidx, 1);
         chk("stall_valid",  l_ovalid, 1);
         chk("stall_iready", l_iready, 0);
      end
      #1 O_ready = 1'b1;
      @(negedge CLK);
      chk("resume_lane2", l_odata, 4'h5);
      @(negedge CLK);
      chk("resume_lane3", l_odata, 4'hA);
      @(negedge CLK);

      // reset pulse in the middle of a clock at cnt = 2
      offer_word(16'hA5C3);
      @(posedge CLK);
      @(posedge CLK);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid",  l_ovalid, 0);
      chk("midrst_data",   l_odata, 0);
      chk("midrst_lindex", l_oidx, 0);
      chk("midrst_mindex", m_oidx, 3);
      chk("midrst_last",   l_olast, 0);
      chk("midrst_iready", l_iready, 0);
      @(posedge CLK);
      #1 rst_n = 1'b1;
      @(negedge CLK);
      chk("postrst_valid",  l_ovalid, 0);
      chk("postrst_iready", l_iready, 1);
      @(negedge CLK);
      chk("postrst_valid2", l_ovalid, 0);
      offer_word(16'h0F0F);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("0f_data",  l_odata, ff_lsb[i]);
         chk("0f_index", l_oidx, i);
      end
      @(negedge CLK);

      // last lane stalled with a new word waiting
      offer_word(16'hA5C3);
      repeat (3) @(posedge CLK);
      #1;
      O_ready = 1'b0;
      I_valid = 1'b1;
      I_data  = 16'h1234;
      repeat (2) begin
         @(negedge CLK);
         chk("laststall_data",   l_odata, 4'hA);
         chk("laststall_last",   l_olast, 1);
         chk("laststall_iready", l_iready, 0);
      end
      #1 O_ready = 1'b1;
      #1 chk("laststall_release_iready", l_iready, 1);
      @(posedge CLK);
      #1 I_valid = 1'b0;
      @(negedge CLK);
      chk("laststall_next_data",  l_odata, 4'h4);
      chk("laststall_next_index", l_oidx, 0);
      chk("laststall_next_last",  l_olast, 0);
      repeat (5) @(negedge CLK);
      chk("final_idle_valid", l_ovalid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/array_unpack.md
# array_unpack

Streaming lane unpacker: accepts one packed word of `NUM_LANES` lanes of `LANE_WIDTH` bits on a valid/ready input and emits the lanes one per cycle on a valid/ready output, in a parameter-selected order. It is the receive-side counterpart of the lane-select/concatenation packing used between instances. It sits downstream of a packed-array producer and feeds lane-serial consumers. A single holding register plus a lane counter gives full throughput (one lane per cycle, no bubble between words) under continuous ready.

## Interface
- `LANE_WIDTH`, 4, bits per lane (≥1).
- `NUM_LANES`, 4, lanes per packed word (≥2).
- `LSB_FIRST`, 1, 1: emit lane 0 (bits `[LANE_WIDTH-1:0]`) first; 0: emit lane `NUM_LANES-1` first.
- `IDXW`, derived `$clog2(NUM_LANES)`, width of `O_index` (not user-set).
- `CLK  in  1`  sole clock, rising edge.
- `ASYNCRESETN  in  1`  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `I_valid  in  1`  packed word present.
- `I_ready  out  1`  unpacker accepts the word this cycle.
- `I_data  in  LANE_WIDTH*NUM_LANES`  packed word; lane k = `I_data[k*LANE_WIDTH +: LANE_WIDTH]`.
- `O_valid  out  1`  lane present.
- `O_ready  in  1`  consumer takes the lane this cycle.
- `O_data  out  LANE_WIDTH`  current lane.
- `O_index  out  IDXW`  physical lane number k of `O_data`.
- `O_last  out  1`  high with the final lane of a word.

## Operation
- State: `hold` (packed word register), `busy` flag, `cnt` (0..NUM_LANES-1, emission position).
- Lane mapping: `O_index = LSB_FIRST ? cnt : NUM_LANES-1-cnt`; `O_data = hold` lane `O_index`; `O_last = busy && cnt == NUM_LANES-1`.
- `O_valid = busy`. All outputs come directly from registers via the lane mux; no combinational path from `I_*` to `O_*`.
- Output transfer: `O_valid && O_ready`. On a non-last transfer, `cnt` increments.
- `I_ready = ASYNCRESETN && (!busy || (O_ready && O_last))`. This is combinational from `O_ready`; there is no path from `I_valid` to `I_ready`.
- Input transfer (`I_valid && I_ready`):
  - `hold <= I_data`, `cnt <= 0`, `busy <= 1`.
  - This takes priority over the last-lane retire in the same cycle, giving back-to-back words.
- Last-lane transfer with no input transfer: `busy <= 0`, `cnt <= 0`.
- `O_ready` low: `cnt`, `hold`, and all outputs stay frozen (AXI-style stability). `O_valid` never drops without a transfer.
- `I_data` is sampled only on input transfer. Changes while `I_ready = 0` are ignored.
- States:
  - IDLE (`busy = 0`): `I_ready = 1`.
  - EMIT (`busy = 1`): `I_ready` is high only on the last-lane transfer cycle.

## Timing
- Reset (`ASYNCRESETN = 0`, takes effect immediately, no clock needed):
  - `busy = 0`, `cnt = 0`, `hold = 0`.
  - `O_valid = 0`, `O_data = 0`, `O_index = LSB_FIRST ? 0 : NUM_LANES-1`, `O_last = 0`, `I_ready = 0`.
  - `I_ready` rises with reset deassertion.
- Latency: word accepted at edge t; its first lane is valid in cycle t+1.
- Throughput: with `O_ready = 1` continuously, each word occupies exactly `NUM_LANES` output cycles and the next word's lane 0 follows the previous last lane with zero gap.
- Reset mid-word: the in-flight word is discarded. No partial lanes appear after release.
- Input offered while EMIT with `cnt < NUM_LANES-1`: stalled (`I_ready = 0`) until the last-lane transfer cycle.

## Test plan
- Defaults, `LSB_FIRST = 1`, `I_data = 16'hA5C3`, `O_ready = 1`:
  - `O_data` = 3, C, 5, A on cycles t+1..t+4.
  - `O_index` = 0, 1, 2, 3.
  - `O_last` only with A.
  - `I_ready` = 0 on t+1..t+3 and 1 on t+4.
- `LSB_FIRST = 0`, same word: `O_data` = A, 5, C, 3; `O_index` = 3, 2, 1, 0.
- Back-to-back words 16'h1234 then 16'hFEDC, with `I_valid` held high and `O_ready = 1`: 8 consecutive valid cycles emitting 4, 3, 2, 1, C, D, E, F; `O_last` on 1 and F.
- `O_ready` low for 3 cycles at `cnt = 1` of 16'hA5C3: `O_data = C`, `O_index = 1`, `O_valid = 1` held stable; `I_ready = 0`; emission resumes with 5, A.
- `ASYNCRESETN` pulsed low mid-clock at `cnt = 2`:
  - Outputs go to reset values immediately.
  - After release, `O_valid = 0` until a new word.
  - The next word 16'h0F0F emits F, 0, F, 0 from lane 0.
- Last lane stalled (`O_ready = 0`) with `I_valid = 1`: `I_ready = 0` until `O_ready` rises; new word accepted the same cycle the last lane retires.
